// File: rtl/updown_cnt_ctrl.sv
// Purpose : sequences a WIDTH-bit up/down/bounce/wrap counter between latched bounds lo..hi.
// Latency : accepted start -> busy=1 and y=initial value one edge later; each RUN tick moves y one step on the next edge.
// Backpr. : none; tick is a pure count-enable strobe, start is ignored while busy, stop aborts immediately.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          start command (IDLE only); lo/hi/mode latched when accepted
//   stop           abort command (RUN only), wins over tick
//   mode[1:0]      00 up-once, 01 down-once, 10 bounce, 11 up-wrap
//   lo, hi         unsigned bounds; start with lo>hi is rejected via err
//   tick           one count step per cycle high while in RUN
//   y, dir         registered count value and direction (1 = up)
//   busy           high while in RUN
//   done           one-cycle pulse when a once-mode run reaches its end bound
//   err            one-cycle pulse when a start is rejected
module updown_cnt_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             tick,
  output logic [WIDTH-1:0] y,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_WRAP   = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [1:0]       mode_q, mode_d;

  // Bounds are only compared against the latched copies, so host-side
  // changes to lo/hi/mode during a run cannot disturb the sequence.
  logic at_hi;
  logic at_lo;
  logic degenerate;

  assign at_hi      = (y_q == hi_q);
  assign at_lo      = (y_q == lo_q);
  assign degenerate = (lo_q == hi_q);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mode_d  = mode_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lo > hi) begin
            // Rejected: nothing but the error pulse changes.
            err_d = 1'b1;
          end else begin
            lo_d    = lo;
            hi_d    = hi;
            mode_d  = mode;
            state_d = ST_RUN;
            if (mode == MODE_DOWN) begin
              y_d   = hi;
              dir_d = 1'b0;
            end else begin
              y_d   = lo;
              dir_d = 1'b1;
            end
          end
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (dir_q) begin
            if (!at_hi) begin
              y_d = y_q + 1'b1;
            end else begin
              unique case (mode_q)
                MODE_UP: begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end
                MODE_BOUNCE: begin
                  // Turning at the top bound consumes this tick as a
                  // step downwards, unless the range is a single value.
                  dir_d = 1'b0;
                  if (!degenerate) begin
                    y_d = y_q - 1'b1;
                  end
                end
                MODE_WRAP: begin
                  y_d = lo_q;
                end
                default: begin
                  // Down-once never counts up; hold.
                end
              endcase
            end
          end else begin
            if (!at_lo) begin
              y_d = y_q - 1'b1;
            end else begin
              unique case (mode_q)
                MODE_DOWN: begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end
                MODE_BOUNCE: begin
                  dir_d = 1'b1;
                  if (!degenerate) begin
                    y_d = y_q + 1'b1;
                  end
                end
                default: begin
                  // Up-once and wrap never count down; hold.
                end
              endcase
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
    end
  end

  assign y    = y_q;
  assign dir  = dir_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
module tb_updown_cnt_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             tick;
  logic [WIDTH-1:0] y;
  logic             dir;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  updown_cnt_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .lo    (lo),
    .hi    (hi),
    .tick  (tick),
    .y     (y),
    .dir   (dir),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: plain integers, end-of-range found by ordering.
  int m_run, m_y, m_dir, m_done, m_err, m_lo, m_hi, m_mode;

  always @(posedge clk) begin
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      m_run = 0; m_y = 0; m_dir = 1; m_lo = 0; m_hi = 0; m_mode = 0;
    end else if (m_run == 0) begin
      if (start) begin
        if (int'(lo) > int'(hi)) begin
          m_err = 1;
        end else begin
          m_lo = int'(lo); m_hi = int'(hi); m_mode = int'(mode); m_run = 1;
          m_y   = (m_mode == 1) ? m_hi : m_lo;
          m_dir = (m_mode == 1) ? 0 : 1;
        end
      end
    end else if (stop) begin
      m_run = 0;
    end else if (tick) begin
      if (m_dir == 1 && m_y < m_hi)      m_y = m_y + 1;
      else if (m_dir == 0 && m_y > m_lo) m_y = m_y - 1;
      else begin
        case (m_mode)
          0, 1: begin m_run = 0; m_done = 1; end
          2: begin
            m_dir = 1 - m_dir;
            if (m_lo != m_hi) m_y = (m_dir == 1) ? m_y + 1 : m_y - 1;
          end
          default: m_y = m_lo;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("y",    int'(y),    m_y);
      chk("dir",  int'(dir),  m_dir);
      chk("busy", int'(busy), m_run);
      chk("done", int'(done), m_done);
      chk("err",  int'(err),  m_err);
      if (done && err) chk("done_err_exclusive", 1, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; tick = 1'b0; rst = 1'b0;
  endtask

  task automatic do_start(input int md, input int l, input int h);
    start = 1'b1; mode = 2'(md); lo = 4'(l); hi = 4'(h);
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_y[$];
    start = 1'b0; stop = 1'b0; tick = 1'b0; rst = 1'b1;
    mode = 2'b00; lo = '0; hi = '0;
    @(negedge clk);
    step();
    cmp_en = 1'b1;
    rst = 1'b0;
    chk("rst_y", int'(y), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_err", int'(done) + int'(err), 0);

    // Up-once 3..6, continuous tick.
    tick = 1'b1;
    do_start(0, 3, 6);
    chk("up_first", int'(y), 3);
    exp_y = '{4, 5, 6};
    foreach (exp_y[i]) begin step(); chk("up_seq", int'(y), exp_y[i]); end
    chk("up_busy_at_hi", int'(busy), 1);
    step();
    chk("up_done", int'(done), 1);
    chk("up_idle", int'(busy), 0);
    chk("up_hold", int'(y), 6);
    step();
    chk("up_done_one_cycle", int'(done), 0);

    // Down-once 2..5, tick on alternate cycles.
    tick = 1'b0;
    do_start(1, 2, 5);
    chk("dn_first", int'(y), 5);
    exp_y = '{4, 4, 3, 3, 2, 2};
    foreach (exp_y[i]) begin
      tick = (i % 2 == 0);
      step();
      chk("dn_seq", int'(y), exp_y[i]);
      chk("dn_dir", int'(dir), 0);
    end
    tick = 1'b1;
    step();
    chk("dn_done", int'(done), 1);
    chk("dn_hold", int'(y), 2);
    tick = 1'b0;
    step();

    // Bounce 0..2, then stop.
    tick = 1'b1;
    do_start(2, 0, 2);
    chk("bn_first", int'(y), 0);
    exp_y = '{1, 2, 1, 0, 1, 2};
    foreach (exp_y[i]) begin step(); chk("bn_seq", int'(y), exp_y[i]); end
    chk("bn_dir_up", int'(dir), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("bn_stop_idle", int'(busy), 0);
    chk("bn_stop_hold", int'(y), 2);
    chk("bn_stop_nodone", int'(done), 0);

    // Wrap 13..15, then reset mid-run.
    do_start(3, 13, 15);
    exp_y = '{14, 15, 13, 14};
    chk("wr_first", int'(y), 13);
    foreach (exp_y[i]) begin step(); chk("wr_seq", int'(y), exp_y[i]); end
    do_reset();
    chk("wr_rst_y", int'(y), 0);
    chk("wr_rst_busy", int'(busy), 0);
    chk("wr_rst_dir", int'(dir), 1);

    // Rejected start, then valid start.
    do_start(0, 9, 4);
    chk("bad_err", int'(err), 1);
    chk("bad_busy", int'(busy), 0);
    chk("bad_y", int'(y), 0);
    step();
    chk("bad_err_one_cycle", int'(err), 0);
    do_start(0, 4, 9);
    chk("good_after_bad", int'(busy), 1);

    // Stop beats tick; start in RUN ignored.
    do_reset();
    tick = 1'b1;
    do_start(3, 1, 3);
    step();
    chk("ign_y", int'(y), 2);
    start = 1'b1; lo = 4'd7; hi = 4'd9; mode = 2'b00;
    step();
    start = 1'b0;
    chk("ign_y2", int'(y), 3);
    step();
    chk("ign_wrap_old_lo", int'(y), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_wins_y", int'(y), 1);
    chk("stop_wins_busy", int'(busy), 0);

    // Degenerate bounce 5..5: y constant, dir toggles.
    do_start(2, 5, 5);
    step();
    chk("deg_dir0", int'(dir), 0);
    step();
    chk("deg_dir1", int'(dir), 1);
    chk("deg_y", int'(y), 5);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Randomized phase; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      tick  = ($urandom_range(0, 2) != 0);
      mode  = 2'($urandom_range(0, 3));
      lo    = 4'($urandom_range(0, 15));
      hi    = ($urandom_range(0, 3) == 0) ? lo : 4'($urandom_range(0, 15));
      step();
    end

    idle_inputs();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
